rs_enc_framer: RTL
==================

# rs_enc_framer

Transmit-side front end of the RS codec path. Accepts a 32-bit AXI-Stream packet stream, serializes each word MSB-byte-first into an 8-bit AXI-Stream, and cuts the byte stream into RS message blocks of exactly K bytes. It asserts tlast on byte K of every block and zero-pads the final block of a packet. Output feeds the RS encoder, so a packet written here returns as the same byte order through the decode path's 8→32 output FIFO, with padding appended.

## Interface
- K, 223: message bytes per RS codeword. Legal range 4..255.
- PAD_BYTE, 8'h00: fill value for the padded tail of a packet's last block.
- core_clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_axis_tdata  in  32  input word; byte [31:24] is transmitted first.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tlast  in  1  last word of packet.
- s_axis_tready  out  1  input accept.
- m_axis_tdata  out  8  output byte to RS encoder.
- m_axis_tvalid  out  1  output byte valid.
- m_axis_tlast  out  1  last byte of a K-byte block.
- m_axis_tready  in  1  encoder accept.
- block_count  out  16  blocks emitted; increments on each tlast handshake; wraps 0xFFFF→0.
- pad_count  out  16  total PAD bytes emitted; wraps.

## Operation
- Registers: hold[31:0], hold_last, byte_idx (0..3), blk_cnt (0..K-1), state ∈ {IDLE, SHIFT, PAD}.
- IDLE: s_axis_tready=1, m_axis_tvalid=0. On s handshake: load hold/hold_last, byte_idx=0, go SHIFT.
- SHIFT: m_axis_tvalid=1, m_axis_tdata=hold byte byte_idx (idx0=[31:24] … idx3=[7:0]), m_axis_tlast=(blk_cnt==K-1). On m handshake: byte_idx++, blk_cnt wraps K-1→0, else ++.
- End of word (m handshake with byte_idx==3):
  - hold_last=0: s_axis_tready=1 combinationally in this cycle. If s_axis_tvalid, reload and stay in SHIFT (no bubble). Otherwise go IDLE.
  - hold_last=1 and blk_cnt==K-1: block closes exactly; go IDLE, no pad.
  - hold_last=1 and blk_cnt<K-1: go PAD. s_axis_tready=0.
- PAD: m_axis_tvalid=1, m_axis_tdata=PAD_BYTE, tlast=(blk_cnt==K-1). Each handshake bumps pad_count and blk_cnt. The tlast handshake goes to IDLE with blk_cnt=0.
- A block boundary falling inside a word (tlast on byte_idx 0..2) does not stall. The remaining bytes start the next block.
- s_axis_tready is 0 in SHIFT except the end-of-word case, and 0 in PAD.
- Held m outputs (tdata, tvalid, tlast) stay stable while m_axis_tready=0 (AXIS rule).
- A packet never produces an empty block. Each packet starts at blk_cnt=0.

## Timing
- Reset (async assert, sync release): state=IDLE, hold=0, byte_idx=0, blk_cnt=0, m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0, block_count=0, pad_count=0. s_axis_tready=0 while rst=1, and 1 from the first cycle after release.
- Latency: word accepted at edge N → byte 0 valid after edge N, visible cycle N+1.
- Throughput: 1 byte/cycle sustained with m_axis_tready=1. Words are accepted every 4 cycles with no gap between words.
- Reset mid-packet discards the held word, partial block, and pad state. No tlast is emitted for the abandoned block.
- m_axis_tready low for any length freezes all state. Counters change only on handshakes.

## Test plan
- K=8, one 2-word packet 0x01020304, 0x05060708 (tlast), m_ready=1 → bytes 01..08 on 8 consecutive cycles; tlast on 08; block_count=1, pad_count=0; s_ready high on the cycle byte 04 handshakes.
- K=6, 1-word packet 0xAABBCCDD (tlast) → AA BB CC DD 00 00; tlast on 2nd 00; pad_count=2; s_ready=0 through pad.
- K=6, 3-word packet 0x00010203, 0x04050607, 0x08090A0B (tlast) → block1 00..05 with tlast on 05; block2 06..0B with tlast on 0B; no pad; no stall between blocks.
- Backpressure: K=8, m_ready toggled 1,0,0,1 pattern → byte sequence and tlast placement identical to the unstalled run; tdata held stable during every ready=0 cycle.
- Assert rst after 3 bytes of a K=8 packet, then send new packet 0x11223344 (tlast) → outputs 11 22 33 44 00 00 00 00 with tlast on last 00; block_count=1 (counter reset to 0, then incremented once).
- Back-to-back packets: K=4, packets 0xDEADBEEF(tlast) then 0x12345678(tlast) with s_valid held → two blocks, 8 consecutive valid cycles, tlast on EF and 78, pad_count=0.

Source files
------------

// File: rtl/rs_enc_framer.sv
// Serializes a 32-bit AXI-Stream packet stream MSB byte first into 8-bit RS
// message blocks of K bytes, zero-padding the last block of each packet.
module rs_enc_framer #(
  parameter int unsigned K        = 223,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] block_count,
  output logic [15:0] pad_count
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  state_t        state, state_n;
  logic [31:0]   hold, hold_n;
  logic          hold_last, hold_last_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [CW-1:0] blk_cnt, blk_cnt_n;
  logic [7:0]    tdata_n;
  logic          tvalid_n, tlast_n;
  logic [15:0]   block_count_n, pad_count_n;
  logic          m_hs, s_hs, eow, can_reload;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    sel_byte = w[31:24];
      2'd1:    sel_byte = w[23:16];
      2'd2:    sel_byte = w[15:8];
      default: sel_byte = w[7:0];
    endcase
  endfunction

  // Next word may enter in IDLE, or on the last byte of a word unless a pad tail must follow.
  assign m_hs          = m_axis_tvalid & m_axis_tready;
  assign eow           = (state == SHIFT) && (byte_idx == 2'd3) && m_hs;
  assign can_reload    = eow && (!hold_last || (blk_cnt == LAST_IDX));
  assign s_axis_tready = !rst && ((state == IDLE) || can_reload);
  assign s_hs          = s_axis_tvalid & s_axis_tready;

  always_comb begin
    state_n       = state;
    hold_n        = hold;
    hold_last_n   = hold_last;
    byte_idx_n    = byte_idx;
    blk_cnt_n     = blk_cnt;
    block_count_n = block_count;
    pad_count_n   = pad_count;

    if (m_hs && m_axis_tlast) block_count_n = block_count + 16'd1;

    case (state)
      IDLE: begin
        if (s_hs) begin
          hold_n      = s_axis_tdata;
          hold_last_n = s_axis_tlast;
          byte_idx_n  = 2'd0;
          state_n     = SHIFT;
        end
      end
      SHIFT: begin
        if (m_hs) begin
          blk_cnt_n = (blk_cnt == LAST_IDX) ? '0 : blk_cnt + CW'(1);
          if (byte_idx != 2'd3) begin
            byte_idx_n = byte_idx + 2'd1;
          end else if (s_hs) begin
            hold_n      = s_axis_tdata;
            hold_last_n = s_axis_tlast;
            byte_idx_n  = 2'd0;
          end else if (!hold_last || (blk_cnt == LAST_IDX)) begin
            state_n = IDLE;
          end else begin
            state_n = PAD;
          end
        end
      end
      PAD: begin
        if (m_hs) begin
          pad_count_n = pad_count + 16'd1;
          if (blk_cnt == LAST_IDX) begin
            blk_cnt_n = '0;
            state_n   = IDLE;
          end else begin
            blk_cnt_n = blk_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Output byte is registered from the next-state view so it appears one cycle after acceptance.
    tvalid_n = (state_n != IDLE);
    tlast_n  = (state_n != IDLE) && (blk_cnt_n == LAST_IDX);
    case (state_n)
      SHIFT:   tdata_n = sel_byte(hold_n, byte_idx_n);
      PAD:     tdata_n = PAD_BYTE;
      default: tdata_n = m_axis_tdata;
    endcase
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold          <= '0;
      hold_last     <= 1'b0;
      byte_idx      <= '0;
      blk_cnt       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      block_count   <= '0;
      pad_count     <= '0;
    end else begin
      state         <= state_n;
      hold          <= hold_n;
      hold_last     <= hold_last_n;
      byte_idx      <= byte_idx_n;
      blk_cnt       <= blk_cnt_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      block_count   <= block_count_n;
      pad_count     <= pad_count_n;
    end
  end

endmodule
